yarp_mem_responder: RTL and testbench
=====================================

# yarp_mem_responder

Backing-memory responder on the far side of the YARP cache refill/writeback interface. Accepts one request at a time from a cache (I-cache refill or D-cache word write), waits a programmable access latency, then returns a full line as a beat-per-word burst (reads) or a single acknowledge beat (writes). It is the memory-side end of the protocol initiated by `cache_top` and `d_cache_top`, and is used both as the simulation main memory and as the synthesizable on-chip backing RAM.

## Interface
- `LINE_WORDS`, 4: words per cache line; power of two, 2..16.
- `DEPTH_WORDS`, 1024: storage depth in 32-bit words; power of two.
- `LATENCY`, 4: cycles from request acceptance to first response beat; 1..15.
- `MEM_INIT_FILE`, "": hex image loaded at time zero if non-empty.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present; held until accepted.
- `req_ready_o`  out  1  responder idle and able to accept.
- `req_addr_i`  in  32  byte address.
- `req_wr_i`  in  1  1 = word write, 0 = line read.
- `req_wr_data_i`  in  32  write data.
- `req_byte_en_i`  in  4  write byte enables.
- `rsp_valid_o`  out  1  response beat valid.
- `rsp_ready_i`  in  1  requester accepts beat.
- `rsp_data_o`  out  32  read word (0 on write acknowledge).
- `rsp_word_idx_o`  out  $clog2(LINE_WORDS)  word index within line of this beat.
- `rsp_last_o`  out  1  final beat of the response.
- `busy_o`  out  1  request in flight (state != RSP_IDLE).

## Operation
- FSM states: RSP_IDLE, RSP_WAIT, RSP_BURST.
- RSP_IDLE: `req_ready_o`=1. On `req_valid_i & req_ready_o`, capture address/write fields, load latency counter with LATENCY-1, go to RSP_WAIT (or directly to RSP_BURST when LATENCY=1).
- RSP_WAIT: decrement counter; at 0 go to RSP_BURST and present the first beat.
- Write: byte-enabled write to word `req_addr_i[2 +: $clog2(DEPTH_WORDS)]` committed on entry to RSP_BURST; single beat, `rsp_last_o`=1, `rsp_data_o`=0, idx = requested word index.
- Read: line base = address with low `$clog2(LINE_WORDS)+2` bits cleared; LINE_WORDS beats, index advances only on `rsp_valid_o & rsp_ready_i`; `rsp_last_o` high on the final beat only.
- After the last beat handshake, return to RSP_IDLE; `req_ready_o` is high in the following cycle (no back-to-back acceptance on the same edge).
- Address bits above the storage range are ignored (index wraps modulo DEPTH_WORDS).
- `rsp_data_o`, `rsp_word_idx_o`, `rsp_last_o` are registered and held stable while `rsp_valid_o & !rsp_ready_i`.
- Reset mid-operation: state aborts to RSP_IDLE immediately; in-flight response discarded; storage contents preserved (not reset); a write not yet committed is dropped.

## Timing
- Reset values: `req_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_word_idx_o`=0, `rsp_last_o`=0, `busy_o`=0.
- Request accepted at edge k -> `rsp_valid_o` rises at edge k+LATENCY.
- Read with `rsp_ready_i` tied high: beats at edges k+LATENCY .. k+LATENCY+LINE_WORDS-1; `req_ready_o` rises at edge k+LATENCY+LINE_WORDS.
- Each low cycle of `rsp_ready_i` during a burst stretches it by exactly one cycle.

## Configuration
- `YARP_MEM_RESP_CWF_EN` defined: critical-word-first; read burst starts at the requested word and wraps within the line (e.g. word 2 of 4: 2,3,0,1).
- Not defined: bursts always start at word 0 in ascending order, regardless of the requested word.

## Structure
- `yarp_pkg`: `mem_resp_state_t` enum {RSP_IDLE, RSP_WAIT, RSP_BURST}; default constants `YARP_LINE_WORDS`=4, `YARP_MEM_LATENCY`=4.
- One sub-module: `yarp_mem_resp_array` — DEPTH_WORDS x 32 single-port RAM with per-byte write enable and registered read.

## Test plan
- Reset, then read 0x0000_1008 (defaults, ready high) -> first beat at acceptance+4; idx 0,1,2,3, data = words 0x1000..0x100C, last on idx 3.
- Write 0xDEADBEEF to 0x20 with byte_en 4'b0011, then read line 0x20 -> word 0 = old[31:16]:BEEF; single ack beat with data 0 for the write.
- `YARP_MEM_RESP_CWF_EN` set, read 0x1008 -> idx order 2,3,0,1; last on idx 1.
- Read with `rsp_ready_i` low for 2 cycles on beat 1 -> beat 1 data/idx held stable; burst ends 2 cycles late.
- Assert `reset_n` low during beat 2 -> all outputs at reset values next cycle; subsequent read returns unmodified memory.
- Read address 0x0000_1000 + DEPTH_WORDS*4 -> same data as 0x1000 (wrap).

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared types and default constants for the YARP memory-side blocks.
// Holds the responder FSM state encoding and the default line/latency sizing.
// Imported by the responder top and its storage array.
package yarp_pkg;

  typedef enum logic [1:0] {
    RSP_IDLE  = 2'd0,
    RSP_WAIT  = 2'd1,
    RSP_BURST = 2'd2
  } mem_resp_state_t;

  localparam int YARP_LINE_WORDS      = 4;
  localparam int YARP_MEM_LATENCY     = 4;
  localparam int YARP_MEM_DEPTH_WORDS = 1024;

endpackage

// File: rtl/yarp_mem_resp_array.sv
// DEPTH_WORDS x 32 single-port storage with per-byte write enables.
// Latency: read data appears one cycle after re_i (registered read port).
// Backpressure: none; read register holds its value while re_i is low.
module yarp_mem_resp_array #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Storage is deliberately not reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/yarp_mem_responder.sv
// Backing-memory responder: one request at a time, line-read bursts or word-write acks.
// Latency: first response beat LATENCY cycles after acceptance; one beat per cycle after.
// Backpressure: rsp_ready_i low holds the current beat stable; req_ready_o only when idle.
// Optional: define YARP_MEM_RESP_CWF_EN for critical-word-first read bursts.
module yarp_mem_responder
  import yarp_pkg::*;
#(
  parameter int    LINE_WORDS    = YARP_LINE_WORDS,
  parameter int    DEPTH_WORDS   = YARP_MEM_DEPTH_WORDS,
  parameter int    LATENCY       = YARP_MEM_LATENCY,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [31:0]                   req_addr_i,
  input  logic                          req_wr_i,
  input  logic [31:0]                   req_wr_data_i,
  input  logic [3:0]                    req_byte_en_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [31:0]                   rsp_data_o,
  output logic [$clog2(LINE_WORDS)-1:0] rsp_word_idx_o,
  output logic                          rsp_last_o,
  output logic                          busy_o
);

  localparam int IDXW = $clog2(LINE_WORDS);
  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int LNW  = AW - IDXW;

  localparam logic [3:0]      LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [IDXW-1:0] LAST_CNT = IDXW'(LINE_WORDS - 1);

  // The image name is consumed by tool-side RAM preload flows, not by this logic.
  localparam bit unused_has_init_file = (MEM_INIT_FILE != "");

  // Byte-offset bits and address bits above the storage range never select storage.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[1:0], req_addr_i[31:2+AW]};

  mem_resp_state_t state_q;
  logic [3:0]      lat_cnt_q;
  logic [LNW-1:0]  line_q;
  logic [IDXW-1:0] word_q;
  logic            wr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic [IDXW-1:0] beat_cnt_q;
  logic            rsp_valid_q;
  logic [IDXW-1:0] rsp_idx_q;
  logic            rsp_last_q;

  logic [IDXW-1:0] first_idx;
  logic [IDXW-1:0] next_idx;
  logic            first_beat;
  logic            ram_we;
  logic            ram_re;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_rdata;

`ifdef YARP_MEM_RESP_CWF_EN
  assign first_idx = word_q;
`else
  assign first_idx = '0;
`endif

  // Word index wraps inside the line, which also covers the critical-word-first order.
  assign next_idx   = rsp_idx_q + IDXW'(1);
  assign first_beat = (state_q == RSP_WAIT) && (lat_cnt_q == 4'd0);

  // Storage access: the write commits, or the first word is fetched, on the edge that
  // enters RSP_BURST; later words are fetched on the edge that retires the previous beat.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = {line_q, word_q};
    if (first_beat) begin
      if (wr_q) begin
        ram_we = 1'b1;
      end else begin
        ram_re   = 1'b1;
        ram_addr = {line_q, first_idx};
      end
    end else if ((state_q == RSP_BURST) && rsp_ready_i && !rsp_last_q) begin
      ram_re   = 1'b1;
      ram_addr = {line_q, next_idx};
    end
  end

  yarp_mem_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (be_q),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Request/response sequencing. Every request passes through RSP_WAIT (counter loaded
  // with LATENCY-1) so the first beat lands exactly LATENCY edges after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RSP_IDLE;
      lat_cnt_q   <= '0;
      line_q      <= '0;
      word_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        RSP_IDLE: begin
          if (req_valid_i) begin
            line_q    <= req_addr_i[2+IDXW +: LNW];
            word_q    <= req_addr_i[2 +: IDXW];
            wr_q      <= req_wr_i;
            wdata_q   <= req_wr_data_i;
            be_q      <= req_byte_en_i;
            lat_cnt_q <= LAT_LOAD;
            state_q   <= RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          if (lat_cnt_q == 4'd0) begin
            state_q     <= RSP_BURST;
            rsp_valid_q <= 1'b1;
            beat_cnt_q  <= '0;
            rsp_idx_q   <= wr_q ? word_q : first_idx;
            rsp_last_q  <= wr_q;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        RSP_BURST: begin
          if (rsp_ready_i) begin
            if (rsp_last_q) begin
              state_q     <= RSP_IDLE;
              rsp_valid_q <= 1'b0;
              rsp_last_q  <= 1'b0;
            end else begin
              rsp_idx_q  <= next_idx;
              beat_cnt_q <= beat_cnt_q + IDXW'(1);
              rsp_last_q <= ((beat_cnt_q + IDXW'(1)) == LAST_CNT);
            end
          end
        end
        default: begin
          state_q     <= RSP_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o    = (state_q == RSP_IDLE);
  assign busy_o         = (state_q != RSP_IDLE);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_word_idx_o = rsp_idx_q;
  assign rsp_last_o     = rsp_last_q;
  // Read register only advances on a handshake, so data holds during a stall.
  assign rsp_data_o     = (rsp_valid_q && !wr_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_yarp_mem_responder.sv
// Randomized bench for yarp_mem_responder against a word-array reference model.
// Stimulus drives and samples on the falling edge; the DUT acts on the rising edge.
// Covers reset values, latency, bursts, byte enables, stalls, reset abort and wrap.
module tb_yarp_mem_responder;

  localparam int LW   = 4;
  localparam int DW   = 1024;
  localparam int LAT  = 4;
  localparam int IDXW = $clog2(LW);

`ifdef YARP_MEM_RESP_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [31:0]     req_addr_i = '0;
  logic            req_wr_i = 1'b0;
  logic [31:0]     req_wr_data_i = '0;
  logic [3:0]      req_byte_en_i = '0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b1;
  logic [31:0]     rsp_data_o;
  logic [IDXW-1:0] rsp_word_idx_o;
  logic            rsp_last_o;
  logic            busy_o;

  always #5 clk = ~clk;

  yarp_mem_responder #(
    .LINE_WORDS    (LW),
    .DEPTH_WORDS   (DW),
    .LATENCY       (LAT),
    .MEM_INIT_FILE ("")
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_wr_i       (req_wr_i),
    .req_wr_data_i  (req_wr_data_i),
    .req_byte_en_i  (req_byte_en_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_word_idx_o (rsp_word_idx_o),
    .rsp_last_o     (rsp_last_o),
    .busy_o         (busy_o)
  );

  logic [31:0] model_mem [DW];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DW);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_rdy"}, 32'(req_ready_o), 32'd1);
    check_val({tag, "_rsp_vld"}, 32'(rsp_valid_o), 32'd0);
    check_val({tag, "_rsp_dat"}, rsp_data_o, 32'd0);
    check_val({tag, "_rsp_idx"}, 32'(rsp_word_idx_o), 32'd0);
    check_val({tag, "_rsp_last"}, 32'(rsp_last_o), 32'd0);
    check_val({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  // Present a request at a falling edge; it is accepted on the next rising edge.
  task automatic start_req(input logic [31:0] a, input logic wr, input logic [31:0] d,
                           input logic [3:0] be);
    check_val("req_rdy_idle", 32'(req_ready_o), 32'd1);
    req_valid_i   = 1'b1;
    req_addr_i    = a;
    req_wr_i      = wr;
    req_wr_data_i = d;
    req_byte_en_i = be;
    @(negedge clk);
    req_valid_i   = 1'b0;
    req_addr_i    = $urandom;
    req_wr_i      = 1'($urandom);
    req_wr_data_i = $urandom;
    req_byte_en_i = 4'($urandom);
    check_val("busy_after_accept", 32'(busy_o), 32'd1);
    check_val("req_rdy_after_accept", 32'(req_ready_o), 32'd0);
  endtask

  // Count falling edges from acceptance until the first beat shows up.
  task automatic wait_first();
    int lat;
    lat = 0;
    while (!rsp_valid_o && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_val("first_beat_latency", 32'(lat), 32'(LAT));
  endtask

  task automatic run_burst(input logic [31:0] a, input logic wr, input int stall_pct,
                           input int hold_beat, input int hold_cycles);
    int nb, base, w0, start, b, cyc, hold, idx;
    logic rdy;
    nb    = wr ? 1 : LW;
    base  = word_of(a) - (word_of(a) % LW);
    w0    = word_of(a) % LW;
    start = (wr || CWF) ? w0 : 0;
    b     = 0;
    cyc   = 0;
    hold  = hold_cycles;
    while (b < nb && cyc < 200) begin
      idx = (start + b) % LW;
      check_val("rsp_vld", 32'(rsp_valid_o), 32'd1);
      check_val("rsp_idx", 32'(rsp_word_idx_o), 32'(idx));
      check_val("rsp_dat", rsp_data_o, wr ? 32'd0 : model_mem[base + idx]);
      check_val("rsp_last", 32'(rsp_last_o), 32'(b == nb - 1));
      rdy = 1'b1;
      if (b == hold_beat && hold > 0) begin
        rdy = 1'b0;
        hold--;
      end else if ($urandom_range(99) < stall_pct) begin
        rdy = 1'b0;
      end
      rsp_ready_i = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) b++;
    end
    check_val("burst_beats", 32'(b), 32'(nb));
    rsp_ready_i = 1'b1;
    check_val("req_rdy_after_burst", 32'(req_ready_o), 32'd1);
    check_val("rsp_vld_after_burst", 32'(rsp_valid_o), 32'd0);
  endtask

  task automatic run_txn(input logic [31:0] a, input logic wr, input logic [31:0] d,
                         input logic [3:0] be, input int stall_pct, input int hold_beat,
                         input int hold_cycles);
    int w;
    start_req(a, wr, d, be);
    wait_first();
    run_burst(a, wr, stall_pct, hold_beat, hold_cycles);
    if (wr) begin
      w = word_of(a);
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Give every word of lines 0..15 a known value.
    for (int w = 0; w < 64; w++) begin
      run_txn(32'(w * 4), 1'b1, $urandom, 4'hF, 0, -1, 0);
    end

    // Line read from mid-line address.
    run_txn(32'h0000_1008, 1'b0, 32'h0, 4'h0, 0, -1, 0);

    // Partial-byte write then line read back.
    run_txn(32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, -1, 0);
    run_txn(32'h0000_0020, 1'b0, 32'h0, 4'h0, 0, -1, 0);

    // Two stall cycles on beat 1.
    run_txn(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0, 1, 2);

    // Reset while beat 2 is presented.
    start_req(32'h0000_1000, 1'b0, 32'h0, 4'h0);
    wait_first();
    rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_val("abort_at_beat2_idx", 32'(rsp_word_idx_o), 32'd2);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    reset_n = 1'b1;
    @(negedge clk);
    run_txn(32'h0000_1000, 1'b0, 32'h0, 4'h0, 0, -1, 0);

    // Reset before a write commits: the write must vanish.
    start_req(32'h0000_0024, 1'b1, 32'h1234_5678, 4'hF);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("drop_wr");
    reset_n = 1'b1;
    @(negedge clk);
    run_txn(32'h0000_0024, 1'b0, 32'h0, 4'h0, 0, -1, 0);

    // Address above storage range aliases onto the same words.
    run_txn(32'h0000_1000 + 32'(DW * 4), 1'b0, 32'h0, 4'h0, 0, -1, 0);

    // Random mix of reads and writes with aliased upper bits and random stalls.
    for (int t = 0; t < 60; t++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 63)) << 2)
          | 32'($urandom_range(0, 3));
      run_txn(a, ($urandom_range(99) < 35), $urandom, 4'($urandom), 30, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
